serial_subtractor_64: RTL and testbench

Multi-cycle, digit-serial N-bit subtractor. Computes d = a − b − bin and the borrow-out, processing W bits per clock through a registered borrow chain. Operands are captured through a valid/ready input handshake, and results are returned through a valid/ready output handshake. It is the subtract-direction companion to the ripple-carry adder datapath, for use where a full-width combinational chain does not meet timing or area.

---
 rtl/serial_subtractor_64.sv | 93 +++++++++
 tb/tb_serial_subtractor_64.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_64.sv
// Digit-serial N-bit subtractor: d = a - b - bin, one W-bit slice per clock, result after N/W cycles.
// Inputs are accepted only in IDLE; in DONE the result is held until out_ready is seen.
module serial_subtractor_64 #(
  parameter int N = 64,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         ovf
);

  localparam int SLICES = N / W;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    a_sh;
  logic [N-1:0]    b_sh;
  logic [N-W-1:0]  d_sh;
  logic            borrow;
  logic            a_msb;
  logic            b_msb;
  logic [W:0]      slice_sub;
  logic [N-1:0]    d_next;

  // W+1-bit subtract: the top bit is the borrow into the next slice
  assign slice_sub = {1'b0, a_sh[W-1:0]} - {1'b0, b_sh[W-1:0]} - {{W{1'b0}}, borrow};
  // Partial difference fills from the top so the last slice lands in d[N-1 -: W]
  assign d_next    = {slice_sub[W-1:0], d_sh};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            a_msb  <= a[N-1];
            b_msb  <= b[N-1];
            borrow <= bin;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> W;
          b_sh   <= b_sh >> W;
          d_sh   <= d_next[N-1:W];
          borrow <= slice_sub[W];
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(SLICES - 1)) begin
            // Visible result only changes here, so d stays intact during the next RUN
            d     <= d_next;
            bout  <= slice_sub[W];
            ovf   <= (a_msb ^ b_msb) & (a_msb ^ slice_sub[W-1]);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_64.sv
// Self-checking bench for serial_subtractor_64: directed table, backpressure, reset, random stream.
module tb_serial_subtractor_64;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] d;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int failures = 0;

  logic [N+1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] d;
    logic         bout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  serial_subtractor_64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: full-width arithmetic, packed as {ovf, bout, d}
  function automatic logic [N+1:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N:0] r;
    r = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, c};
    return {(x[N-1] ^ y[N-1]) & (x[N-1] ^ r[N-1]), r};
  endfunction

  // Presents one operand set, waits for the result; lat counts edges from acceptance to out_valid
  task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic xc,
                        output logic [N-1:0] rd, output logic rb, output logic ro, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a = xa; b = xb; bin = xc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = d; rb = bout; ro = ovf;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rd, held_d;
    logic         rb, ro, held_b, held_o;
    logic [N+1:0] e;
    int           lat;
    int           got;

    vecs[0] = '{64'h5, 64'h3, 1'b0, 64'h2, 1'b0, 1'b0};
    vecs[1] = '{64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{64'h0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[7] = '{64'h0000_0001_0000_0000, 64'h1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_d", d, 64'd0);
    chk("rst_bout", 64'(bout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, rd, rb, ro, lat);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd8);
      chk($sformatf("vec%0d_d", i), rd, vecs[i].d);
      chk($sformatf("vec%0d_bout", i), 64'(rb), 64'(vecs[i].bout));
      chk($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].ovf));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_drain", i), 64'({out_valid, in_ready}), 64'b01);
    end

    // Backpressure: result held for 5 cycles, in_valid pulses ignored
    out_ready = 1'b0;
    e = ref_sub(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, held_d, held_b, held_o, lat);
    chk("bp_lat", 64'(lat), 64'd8);
    chk("bp_d", held_d, e[N-1:0]);
    chk("bp_bout", 64'(held_b), 64'(e[N]));
    chk("bp_ovf", 64'(held_o), 64'(e[N+1]));
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'({out_valid, in_ready}), 64'b10);
      chk("bp_hold_d", d, held_d);
      chk("bp_hold_flags", 64'({bout, ovf}), 64'({held_b, held_o}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 64'({out_valid, in_ready}), 64'b01);
    @(posedge clk); #1;
    chk("bp_no_queued", 64'({out_valid, in_ready}), 64'b01);

    // Reset in the middle of RUN discards the operation immediately
    a = 64'hDEAD_BEEF_0000_0001; b = 64'h2; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_run_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_ready_valid", 64'({in_ready, out_valid}), 64'b10);
    chk("arst_d", d, 64'd0);
    chk("arst_flags", 64'({bout, ovf}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    e = ref_sub(64'hFEDC_BA98_7654_3210, 64'hFFFF_0000_FFFF_0000, 1'b1);
    run_op(64'hFEDC_BA98_7654_3210, 64'hFFFF_0000_FFFF_0000, 1'b1, rd, rb, ro, lat);
    chk("post_rst_lat", 64'(lat), 64'd8);
    chk("post_rst_d", rd, e[N-1:0]);
    chk("post_rst_flags", 64'({ro, rb}), 64'(e[N+1:N]));
    @(posedge clk); #1;

    // Random stream with input gaps and output stalls
    got = 0;
    fork
      begin : driver
        logic [N-1:0] ra, rbv;
        logic         rc, rdy;
        int           gap, guard, sel;
        for (int i = 0; i < 1000; i++) begin
          gap = $urandom_range(0, 3);
          repeat (gap) begin @(posedge clk); #1; end
          sel = $urandom_range(0, 7);
          ra  = (sel == 0) ? 64'h0 : (sel == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
          sel = $urandom_range(0, 7);
          rbv = (sel == 0) ? 64'h0 : (sel == 1) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
          rc  = 1'($urandom_range(0, 1));
          a = ra; b = rbv; bin = rc; in_valid = 1'b1;
          guard = 0;
          do begin
            rdy = in_ready;
            @(posedge clk); #1;
            guard++;
          end while (!rdy && guard < 200);
          in_valid = 1'b0;
          if (!rdy) begin
            chk("rand_accept_timeout", 64'(guard), 64'd0);
            break;
          end
          exp_q.push_back(ref_sub(ra, rbv, rc));
        end
      end
      begin : monitor
        logic [N+1:0] ex;
        int           cyc;
        cyc = 0;
        while (got < 1000 && cyc < 40000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              chk("rand_unexpected_result", 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
              ex = exp_q.pop_front();
              chk($sformatf("rand%0d_d", got), d, ex[N-1:0]);
              chk($sformatf("rand%0d_flags", got), 64'({ovf, bout}), 64'(ex[N+1:N]));
            end
            got++;
          end
          @(posedge clk); #1;
          cyc++;
        end
      end
    join
    chk("rand_result_count", 64'(got), 64'd1000);
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
